// File: rtl/ssd_scan_capture.sv
// Seven-segment scan observer: filters the multiplexed anode/cathode lines,
// decodes each stable segment pattern back to a hex nibble and keeps a per-digit register file.
module ssd_scan_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int AGE_W         = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        err_clr,
  input  logic [1:0]  rd_sel,
  output logic [3:0]  rd_data,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        frame,
  output logic        anode_err,
  output logic        seg_err
);

  localparam int               CNT_W    = 8;
  localparam logic [CNT_W-1:0] STABLE   = CNT_W'(STABLE_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_MAX - 1'b1;
  localparam logic [10:0]      PAT_BLANK = 11'h7FF;

  // Returns {hit, value}; hit=0 for any pattern outside the hex font.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b0000001: res = {1'b1, 4'h0};
      7'b1001111: res = {1'b1, 4'h1};
      7'b0010010: res = {1'b1, 4'h2};
      7'b0000110: res = {1'b1, 4'h3};
      7'b1001100: res = {1'b1, 4'h4};
      7'b0100100: res = {1'b1, 4'h5};
      7'b0100000: res = {1'b1, 4'h6};
      7'b0001111: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0000100: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b1100000: res = {1'b1, 4'hB};
      7'b0110001: res = {1'b1, 4'hC};
      7'b1000010: res = {1'b1, 4'hD};
      7'b0110000: res = {1'b1, 4'hE};
      7'b0111000: res = {1'b1, 4'hF};
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // Returns {one_cold, index} for an active-low digit enable.
  function automatic logic [2:0] anode_sel(input logic [3:0] an);
    logic [2:0] res;
    case (an)
      4'b1110: res = 3'b1_00;
      4'b1101: res = 3'b1_01;
      4'b1011: res = 3'b1_10;
      4'b0111: res = 3'b1_11;
      default: res = 3'b0_00;
    endcase
    return res;
  endfunction

  logic [10:0]      r_pat_p0;
  logic [CNT_W-1:0] r_cnt_p0;
  logic             r_vld_p1;
  logic [10:0]      r_pat_p1;
  logic [15:0]      r_digits;
  logic [3:0]       r_valid;
  logic [AGE_W-1:0] r_age [4];
  logic             r_upd;
  logic [1:0]       r_upd_idx;
  logic             r_frame;
  logic [3:0]       r_seen;
  logic             r_anode_err;
  logic             r_seg_err;

  logic [10:0]      w_smp;
  logic             w_same;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_evt;
  logic [3:0]       w_an;
  logic [2:0]       w_sel;
  logic [4:0]       w_dec;
  logic             w_blank;
  logic             w_wr;
  logic             w_aerr_evt;
  logic             w_serr_evt;
  logic [3:0]       w_wr_mask;

  // Stage p0: sample and stability counter
  assign w_smp     = {anode, cathode};
  assign w_same    = (w_smp == r_pat_p0);
  assign w_cnt_nxt = !w_same              ? CNT_W'(1) :
                     (r_cnt_p0 == STABLE) ? STABLE    : r_cnt_p0 + 1'b1;
  // One event per stable window: only the step onto STABLE fires.
  assign w_evt     = (w_cnt_nxt == STABLE) && (r_cnt_p0 != STABLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat_p0 <= PAT_BLANK;
      r_cnt_p0 <= '0;
    end else begin
      r_pat_p0 <= w_smp;
      r_cnt_p0 <= w_cnt_nxt;
    end
  end

  // Stage p1: registered capture event with its pattern
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_pat_p1 <= '0;
    end else begin
      r_vld_p1 <= w_evt;
      r_pat_p1 <= w_smp;
    end
  end

  assign w_an       = r_pat_p1[10:7];
  assign w_sel      = anode_sel(w_an);
  assign w_dec      = seg_decode(r_pat_p1[6:0]);
  assign w_blank    = (w_an == 4'hF);
  assign w_wr       = r_vld_p1 && w_sel[2] && w_dec[4];
  assign w_aerr_evt = r_vld_p1 && !w_blank && !w_sel[2];
  assign w_serr_evt = r_vld_p1 && w_sel[2] && !w_dec[4];
  assign w_wr_mask  = w_wr ? (4'b0001 << w_sel[1:0]) : 4'b0000;

  // Stage p2: register file, ageing, frame tracking and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits <= '0;
      r_valid  <= '0;
      for (int i = 0; i < 4; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_mask[i]) begin
          // A capture on the timeout cycle keeps the digit alive.
          r_digits[4*i +: 4] <= w_dec[3:0];
          r_valid[i]         <= 1'b1;
          r_age[i]           <= '0;
        end else if (r_valid[i]) begin
          if (r_age[i] != AGE_MAX) r_age[i] <= r_age[i] + 1'b1;
          if (r_age[i] == AGE_LAST) r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
    end else begin
      r_upd <= w_wr;
      if (w_wr) r_upd_idx <= w_sel[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame <= 1'b0;
      r_seen  <= '0;
    end else if (r_seen == 4'hF) begin
      r_frame <= 1'b1;
      r_seen  <= w_wr_mask;
    end else begin
      r_frame <= 1'b0;
      r_seen  <= r_seen | w_wr_mask;
    end
  end

  // A new error on the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode_err <= 1'b0;
      r_seg_err   <= 1'b0;
    end else begin
      if (w_aerr_evt)   r_anode_err <= 1'b1;
      else if (err_clr) r_anode_err <= 1'b0;
      if (w_serr_evt)   r_seg_err <= 1'b1;
      else if (err_clr) r_seg_err <= 1'b0;
    end
  end

  assign rd_data     = r_digits[{rd_sel, 2'b00} +: 4];
  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign upd         = r_upd;
  assign upd_idx     = r_upd_idx;
  assign frame       = r_frame;
  assign anode_err   = r_anode_err;
  assign seg_err     = r_seg_err;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Scoreboard bench for ssd_scan_capture: expected captures and frames are queued
// by the stimulus driver and matched against upd/frame pulses by a monitor.
module tb_ssd_scan_capture;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        err_clr;
  logic [1:0]  rd_sel;
  logic [3:0]  rd_data,  a_rd_data;
  logic [15:0] digits,   a_digits;
  logic [3:0]  digit_valid, a_digit_valid;
  logic        upd, a_upd;
  logic [1:0]  upd_idx, a_upd_idx;
  logic        frame, a_frame;
  logic        anode_err, a_anode_err;
  logic        seg_err, a_seg_err;

  ssd_scan_capture #(.STABLE_CYCLES(STABLE), .AGE_W(20)) dut (
    .clk(clk), .reset(reset), .anode(anode), .cathode(cathode), .err_clr(err_clr),
    .rd_sel(rd_sel), .rd_data(rd_data), .digits(digits), .digit_valid(digit_valid),
    .upd(upd), .upd_idx(upd_idx), .frame(frame), .anode_err(anode_err), .seg_err(seg_err)
  );

  // Short age counter so timeout is reachable.
  ssd_scan_capture #(.STABLE_CYCLES(STABLE), .AGE_W(4)) dut_age (
    .clk(clk), .reset(reset), .anode(anode), .cathode(cathode), .err_clr(err_clr),
    .rd_sel(rd_sel), .rd_data(a_rd_data), .digits(a_digits), .digit_valid(a_digit_valid),
    .upd(a_upd), .upd_idx(a_upd_idx), .frame(a_frame), .anode_err(a_anode_err),
    .seg_err(a_seg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    int         cyc;
    logic [1:0] idx;
    logic [3:0] val;
  } upd_t;

  upd_t sb_q[$];
  int   frm_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b0000001;  4'h1: p = 7'b1001111;
      4'h2: p = 7'b0010010;  4'h3: p = 7'b0000110;
      4'h4: p = 7'b1001100;  4'h5: p = 7'b0100100;
      4'h6: p = 7'b0100000;  4'h7: p = 7'b0001111;
      4'h8: p = 7'b0000000;  4'h9: p = 7'b0000100;
      4'hA: p = 7'b0001000;  4'hB: p = 7'b1100000;
      4'hC: p = 7'b0110001;  4'hD: p = 7'b1000010;
      4'hE: p = 7'b0110000;  default: p = 7'b0111000;
    endcase
    return p;
  endfunction

  // Called just after a rising edge; holds the pattern for n rising edges.
  task automatic drive_raw(input logic [3:0] an, input logic [6:0] cat, input int n);
    anode   = an;
    cathode = cat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_dig(input logic [1:0] idx, input logic [3:0] v, input int n);
    upd_t e;
    if (n >= STABLE) begin
      e.cyc = cyc + STABLE + 1;
      e.idx = idx;
      e.val = v;
      sb_q.push_back(e);
    end
    drive_raw(~(4'b0001 << idx), seg_of(v), n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digits"}, digits, 16'h0);
    chk({tag, "_valid"}, digit_valid, 4'h0);
    chk({tag, "_upd"}, {upd, upd_idx}, 3'b0);
    chk({tag, "_frame"}, frame, 1'b0);
    chk({tag, "_errs"}, {anode_err, seg_err}, 2'b0);
    chk({tag, "_age_inst"}, {a_digits, a_digit_valid, a_upd, a_frame}, 22'h0);
  endtask

  always @(negedge clk) begin : monitor
    upd_t e;
    if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      chk("upd_missing", cyc, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (upd) begin
      if (sb_q.size() == 0) chk("upd_unexpected", sb_q.size(), 1);
      else begin
        e = sb_q.pop_front();
        chk("upd_cyc", cyc, e.cyc);
        chk("upd_idx", upd_idx, e.idx);
        chk("upd_val", digits[4*e.idx +: 4], e.val);
        chk("upd_valid", digit_valid[e.idx], 1'b1);
      end
    end
    if (frm_q.size() > 0 && frm_q[0] < cyc) begin
      chk("frame_missing", cyc, frm_q[0]);
      void'(frm_q.pop_front());
    end
    if (frame) begin
      if (frm_q.size() == 0) chk("frame_unexpected", frm_q.size(), 1);
      else chk("frame_cyc", cyc, frm_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1);
  end

  initial begin
    int u;
    reset   = 1'b1;
    anode   = 4'hF;
    cathode = 7'h7F;
    err_clr = 1'b0;
    rd_sel  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Single capture of digit 0
    drive_dig(2'd0, 4'h4, 10);
    chk("t1_digit0", digits[3:0], 4'h4);
    chk("t1_valid", digit_valid, 4'b0001);
    chk("t1_rd", rd_data, 4'h4);
    drive_raw(4'hF, 7'h7F, 5);

    // Full scan, one frame after digit 3
    reset = 1'b1;
    drive_raw(4'hF, 7'h7F, 2);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) frm_q.push_back(cyc + STABLE + 2);
      drive_dig(2'(i), 4'(4 + i), 8);
    end
    drive_raw(4'hF, 7'h7F, 4);
    chk("scan_digits", digits, 16'h7654);
    chk("scan_valid", digit_valid, 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk("scan_rd", rd_data, 4'(4 + i));
    end
    @(posedge clk);
    #1;

    // Glitch between valid digits, then multi-low anode
    drive_dig(2'd0, 4'h3, 6);
    drive_dig(2'd1, 4'h8, 3);
    drive_dig(2'd2, 4'h1, 6);
    drive_raw(4'hF, 7'h7F, 4);
    chk("glitch_digits", digits, 16'h7153);
    drive_raw(4'b1100, seg_of(4'h2), 6);
    chk("aerr_set", anode_err, 1'b1);
    chk("aerr_no_seg", seg_err, 1'b0);
    chk("aerr_digits", digits, 16'h7153);
    err_clr = 1'b1;
    drive_raw(4'hF, 7'h7F, 1);
    err_clr = 1'b0;
    chk("aerr_clr", anode_err, 1'b0);

    // Blank cathode with one anode low
    drive_dig(2'd1, 4'hE, 6);
    drive_raw(4'b1101, 7'h7F, 6);
    chk("serr_set", seg_err, 1'b1);
    chk("serr_valid1", digit_valid[1], 1'b1);
    chk("serr_digit1", digits[7:4], 4'hE);
    chk("serr_no_aerr", anode_err, 1'b0);
    err_clr = 1'b1;
    drive_raw(4'hF, 7'h7F, 1);
    err_clr = 1'b0;
    chk("serr_clr", seg_err, 1'b0);
    drive_raw(4'hF, 7'h7F, 4);

    // Age timeout on the short-age instance
    reset = 1'b1;
    drive_raw(4'hF, 7'h7F, 2);
    reset = 1'b0;
    u = cyc + STABLE + 1;
    drive_dig(2'd2, 4'h9, 6);
    drive_raw(4'hF, 7'h7F, 1);
    while (cyc < u + 14) @(negedge clk);
    chk("age_valid_before", a_digit_valid[2], 1'b1);
    while (cyc < u + 15) @(negedge clk);
    chk("age_valid_after", a_digit_valid[2], 1'b0);
    chk("age_digit_kept", a_digits[11:8], 4'h9);
    chk("age_long_valid", digit_valid[2], 1'b1);
    @(posedge clk);
    #1;

    // Reset while the stability count sits at 3
    drive_raw(4'b0111, seg_of(4'hA), 3);
    reset = 1'b1;
    drive_raw(4'hF, 7'h7F, 2);
    chk_all_zero("midreset");
    reset = 1'b0;
    drive_raw(4'hF, 7'h7F, 8);
    chk("post_reset_digits", digits, 16'h0);

    chk("sb_empty", sb_q.size(), 0);
    chk("frame_q_empty", frm_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
